scan_chain_sequencer: RTL and testbench

Sequences a serial chain of falling-edge storage flops (CHAIN_LEN deep) for test and configuration access. On request, it optionally captures the chain's functional data, then shifts a parallel word in MSB-first while collecting the old contents into a parallel output word. The block drives chain scan-enable, clock-enable and serial-in, and reads the chain's serial-out.

---
 rtl/scan_chain_sequencer.sv | 112 +++++++++++
 tb/tb_scan_chain_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_sequencer.sv
// rtl/scan_chain_sequencer.sv - drives a falling-edge scan chain: optional capture, MSB-first shift-in, parallel readback
module scan_chain_sequencer #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 CAPTURE,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] DIN,
    input  logic                 SO,
    output logic                 SE,
    output logic                 CE,
    output logic                 SI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] DOUT
);

    typedef enum logic [1:0] {S_IDLE, S_CAPT, S_SHIFT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               state_q, state_d;
    logic [CHAIN_LEN-1:0] in_q, in_d;
    logic [CHAIN_LEN-1:0] out_q, out_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 se_d, ce_d, si_d, busy_d, done_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            in_q    <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            SE      <= 1'b0;
            CE      <= 1'b0;
            SI      <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            DOUT    <= '0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            SE      <= se_d;
            CE      <= ce_d;
            SI      <= si_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
            if (state_d == S_DONE)
                DOUT <= out_q;
        end
    end

    // in_q shifts left each SHIFT cycle so its MSB is always the next bit to send;
    // SO samples enter out_q at the LSB, so the first sample (old chain tail) ends up at the MSB.
    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    in_d  = DIN;
                    cnt_d = '0;
                    if (CAPTURE) begin
                        state_d = S_CAPT;
                    end else begin
                        out_d   = {out_q[CHAIN_LEN-2:0], SO};
                        state_d = S_SHIFT;
                    end
                end
            end
            S_CAPT: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else begin
                    out_d   = {out_q[CHAIN_LEN-2:0], SO};
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else begin
                    in_d  = {in_q[CHAIN_LEN-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST)
                        state_d = S_DONE;
                    else
                        out_d = {out_q[CHAIN_LEN-2:0], SO};
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, giving glitch-free Moore outputs.
    always_comb begin
        se_d   = (state_d == S_SHIFT);
        ce_d   = (state_d == S_SHIFT) || (state_d == S_CAPT);
        busy_d = ce_d;
        done_d = (state_d == S_DONE);
        si_d   = se_d & in_d[CHAIN_LEN-1];
    end

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// tb/tb_scan_chain_sequencer.sv - directed self-checking bench with falling-edge chain models
module tb_scan_chain_sequencer;

    localparam int L = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         start = 1'b0, capture = 1'b0, abort = 1'b0;
    logic [L-1:0] din = '0;
    logic         so, se, ce, si, busy, done;
    logic [L-1:0] dout;
    logic [L-1:0] chain = '0, func = '0, preset_val = '0;
    logic         preload = 1'b0;

    logic         start_b = 1'b0;
    logic [1:0]   din_b = '0;
    logic         so_b, se_b, ce_b, si_b, busy_b, done_b;
    logic [1:0]   dout_b;
    logic [1:0]   chain_b = '0, preset_b = '0;
    logic         preload_b = 1'b0;

    int errors = 0;
    int checks = 0;

    scan_chain_sequencer #(.CHAIN_LEN(L), .CNT_W(5)) dut_a (
        .CLK(clk), .RST(rst), .START(start), .CAPTURE(capture), .ABORT(abort),
        .DIN(din), .SO(so), .SE(se), .CE(ce), .SI(si), .BUSY(busy), .DONE(done), .DOUT(dout)
    );

    scan_chain_sequencer #(.CHAIN_LEN(2), .CNT_W(2)) dut_b (
        .CLK(clk), .RST(rst), .START(start_b), .CAPTURE(1'b0), .ABORT(1'b0),
        .DIN(din_b), .SO(so_b), .SE(se_b), .CE(ce_b), .SI(si_b), .BUSY(busy_b), .DONE(done_b), .DOUT(dout_b)
    );

    assign so   = chain[L-1];
    assign so_b = chain_b[1];

    always @(negedge clk) begin
        if (preload)      chain <= preset_val;
        else if (ce)      chain <= se ? {chain[L-2:0], si} : func;
        if (preload_b)    chain_b <= preset_b;
        else if (ce_b)    chain_b <= se_b ? {chain_b[0], si_b} : 2'b00;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_chain(input logic [L-1:0] v);
        preset_val = v;
        preload = 1'b1;
        step();
        preload = 1'b0;
    endtask

    task automatic run_op(input logic [L-1:0] d, input logic cap, input logic ab,
                          output int se_n, output int ceo_n, output int first_se,
                          output int done_cyc, output int done_n, output logic [L-1:0] si_w);
        din = d; capture = cap; abort = ab; start = 1'b1;
        step();
        start = 1'b0; capture = 1'b0; abort = 1'b0;
        se_n = 0; ceo_n = 0; first_se = -1; done_cyc = -1; done_n = 0; si_w = '0;
        for (int c = 1; c <= 30; c++) begin
            if (se) begin
                se_n++;
                si_w = {si_w[L-2:0], si};
                if (first_se < 0) first_se = c;
            end
            if (ce && !se) ceo_n++;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            step();
        end
    endtask

    initial begin
        int se_n, ceo_n, first_se, done_cyc, done_n, rises, rise2, rise3;
        logic [L-1:0] si_w, snap, held;
        logic prev_busy;

        // Reset state
        step();
        chk("rst_se", se, 0);
        chk("rst_ce", ce, 0);
        chk("rst_si", si, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout", dout, 0);
        rst = 1'b0;
        step();

        // Plain load
        set_chain(16'h1234);
        run_op(16'hA5C3, 1'b0, 1'b0, se_n, ceo_n, first_se, done_cyc, done_n, si_w);
        chk("plain_se_cycles", se_n, 16);
        chk("plain_first_se", first_se, 1);
        chk("plain_done_cycle", done_cyc, 17);
        chk("plain_done_count", done_n, 1);
        chk("plain_si_seq", si_w, 16'hA5C3);
        chk("plain_dout", dout, 16'h1234);
        chk("plain_chain", chain, 16'hA5C3);
        run_op(16'h0000, 1'b0, 1'b0, se_n, ceo_n, first_se, done_cyc, done_n, si_w);
        chk("second_dout", dout, 16'hA5C3);
        chk("second_chain", chain, 16'h0000);

        // Capture mode
        func = 16'hBEEF;
        run_op(16'h0F0F, 1'b1, 1'b0, se_n, ceo_n, first_se, done_cyc, done_n, si_w);
        chk("cap_capture_cycles", ceo_n, 1);
        chk("cap_se_cycles", se_n, 16);
        chk("cap_first_se", first_se, 2);
        chk("cap_done_cycle", done_cyc, 18);
        chk("cap_dout", dout, 16'hBEEF);
        chk("cap_chain", chain, 16'h0F0F);

        // Reset asserted mid-shift at cnt=5
        din = 16'h5555; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("mid_se_before", se, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_se", se, 0);
        chk("mid_rst_ce", ce, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dout", dout, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        snap = chain;
        run_op(16'h3C5A, 1'b0, 1'b0, se_n, ceo_n, first_se, done_cyc, done_n, si_w);
        chk("post_rst_done_cycle", done_cyc, 17);
        chk("post_rst_dout", dout, snap);
        held = snap;

        // Abort at cnt=7
        din = 16'hFFFF; start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("abort_busy_before", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_se", se, 0);
        chk("abort_ce", ce, 0);
        done_n = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) done_n++;
            step();
        end
        chk("abort_no_done", done_n, 0);
        chk("abort_dout_held", dout, held);

        // ABORT together with START in IDLE
        snap = chain;
        run_op(16'h00FF, 1'b0, 1'b1, se_n, ceo_n, first_se, done_cyc, done_n, si_w);
        chk("abst_first_se", first_se, 1);
        chk("abst_done_cycle", done_cyc, 17);
        chk("abst_dout", dout, snap);
        chk("abst_chain", chain, 16'h00FF);

        // START held continuously
        din = 16'h0001; start = 1'b1;
        prev_busy = busy;
        rises = 0; rise2 = -1; rise3 = -1; done_n = 0; done_cyc = -1;
        for (int c = 1; c <= 54; c++) begin
            step();
            if (busy && !prev_busy) begin
                rises++;
                if (rises == 2) rise2 = c;
                if (rises == 3) rise3 = c;
            end
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            prev_busy = busy;
        end
        start = 1'b0;
        chk("b2b_ops", rises, 3);
        chk("b2b_second_start", rise2, 19);
        chk("b2b_third_start", rise3, 37);
        chk("b2b_done_count", done_n, 3);
        chk("b2b_first_done", done_cyc, 17);
        repeat (25) step();
        chk("b2b_chain", chain, 16'h0001);

        // CHAIN_LEN=2 boundary
        preset_b = 2'b01; preload_b = 1'b1;
        step();
        preload_b = 1'b0;
        din_b = 2'b10; start_b = 1'b1;
        step();
        start_b = 1'b0;
        se_n = 0; done_cyc = -1; si_w = '0;
        for (int c = 1; c <= 8; c++) begin
            if (se_b) begin
                se_n++;
                si_w = {si_w[L-2:0], si_b};
            end
            if (done_b && done_cyc < 0) done_cyc = c;
            step();
        end
        chk("l2_se_cycles", se_n, 2);
        chk("l2_si_seq", si_w, 16'h0002);
        chk("l2_done_cycle", done_cyc, 3);
        chk("l2_dout", dout_b, 2'b01);
        chk("l2_chain", chain_b, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
